// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver states, frame width and baud divisor derivation.
package uart_pkg;
   localparam int NBITS = 8;
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_IDLE = 3'd4
   } state_t;
   function automatic int baud_div(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction
endpackage

// File: rtl/uart_byte_receiver_if.sv
// uart_byte_receiver_if: serial line in, byte-valid stream plus status out.
interface uart_byte_receiver_if;
   import uart_pkg::*;
   logic             rx;
   logic [NBITS-1:0] po_data;
   logic             po_flag;
   logic             frame_err;
   logic             busy;
   modport master (input rx, output po_data, po_flag, frame_err, busy);
   modport slave (output rx, input po_data, po_flag, frame_err, busy);
endinterface

// File: rtl/rx_baud_counter.sv
// rx_baud_counter: free-running bit-period counter, pulses and wraps at the terminal value.
module rx_baud_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr_i,
   input  logic         en_i,
   input  logic [W-1:0] term_i,
   output logic         sample_o
);
   logic [W-1:0] cnt_q, cnt_d;
   assign sample_o = en_i && (cnt_q == term_i);
   always_comb cnt_d = (clr_i || sample_o) ? '0 : en_i ? cnt_q + W'(1) : cnt_q;
   always_ff @(posedge clk)
      if (rst) cnt_q <= '0;
      else cnt_q <= cnt_d;
endmodule

// File: rtl/uart_byte_receiver.sv
// uart_byte_receiver: 8N1 UART receiver with mid-bit sampling, feeding a byte-valid stream.
module uart_byte_receiver
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = 50_000_000,
   parameter int BAUD     = 9600
) (
   input logic                  CLK,
   input logic                  RESET,
   uart_byte_receiver_if.master bus
);
   localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD);
   localparam int CW       = $clog2(BAUD_DIV);
   state_t           state_q, state_d;
   logic [1:0]       sync_q;
   logic             rx_d_q, rx_s, sample;
   logic [2:0]       idx_q, idx_d;
   logic [NBITS-1:0] shift_q, shift_d, data_q, data_d;
   logic             flag_q, flag_d, ferr_q, ferr_d;
   logic [CW-1:0]    term;
   assign rx_s = sync_q[1];
   // start bit is sampled at its middle, every later bit one full period on
   assign term = (state_q == START) ? CW'(BAUD_DIV / 2 - 1) : CW'(BAUD_DIV - 1);
   rx_baud_counter #(.W(CW)) u_baud (
      .clk      (CLK),
      .rst      (RESET),
      .clr_i    (state_q == IDLE),
      .en_i     (state_q != IDLE),
      .term_i   (term),
      .sample_o (sample)
   );
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      data_d  = data_q;
      flag_d  = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         IDLE:  if (rx_d_q && !rx_s) state_d = START;
         START: if (sample) begin
            state_d = rx_s ? IDLE : DATA;
            idx_d   = '0;
         end
         DATA:  if (sample) begin
            shift_d[idx_q] = rx_s;
            idx_d          = idx_q + 3'd1;
            state_d        = (idx_q == 3'(NBITS - 1)) ? STOP : DATA;
         end
         STOP:  if (sample) begin
            state_d = rx_s ? IDLE : WAIT_IDLE;
            data_d  = rx_s ? shift_q : data_q;
            flag_d  = rx_s;
            ferr_d  = !rx_s;
         end
         WAIT_IDLE: if (rx_s) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge CLK)
      if (RESET) begin
         state_q <= IDLE;
         sync_q  <= 2'b11;
         rx_d_q  <= 1'b1;
         idx_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         flag_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sync_q  <= {sync_q[0], bus.rx};
         rx_d_q  <= rx_s;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         flag_q  <= flag_d;
         ferr_q  <= ferr_d;
      end
   assign bus.po_data   = data_q;
   assign bus.po_flag   = flag_q;
   assign bus.frame_err = ferr_q;
   assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_uart_byte_receiver.sv
// tb_uart_byte_receiver: scoreboard bench, 16 clocks per bit.
module tb_uart_byte_receiver;
   localparam int BD = 16;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   t_fall = 0;
   int   last_lat = 0;
   int   flag_cnt = 0;
   int   ferr_cnt = 0;
   int   viol = 0;
   logic prev_flag = 1'b0;
   logic prev_ferr = 1'b0;
   logic [7:0] exp_q[$];
   uart_byte_receiver_if bus ();
   uart_byte_receiver #(.CLK_FREQ(1_600_000), .BAUD(100_000)) dut (
      .CLK   (clk),
      .RESET (rst),
      .bus   (bus)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   always @(negedge clk) begin
      if (bus.po_flag) begin
         flag_cnt++;
         last_lat = cyc - t_fall;
         if (exp_q.size() == 0) check("unexpected_flag", 32'(bus.po_data), 32'hdead);
         else check("rx_byte", 32'(bus.po_data), 32'(exp_q.pop_front()));
      end
      if (bus.frame_err) ferr_cnt++;
      if ((bus.po_flag && bus.frame_err) || (bus.po_flag && prev_flag) || (bus.frame_err && prev_ferr)) viol++;
      prev_flag = bus.po_flag;
      prev_ferr = bus.frame_err;
   end
   task automatic drive(input logic v, input int n);
      bus.rx = v;
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic send(input logic [7:0] b, input logic stop);
      t_fall = cyc;
      drive(1'b0, BD);
      for (int i = 0; i < 8; i++) drive(b[i], BD);
      drive(stop, BD);
   endtask
   task automatic wait_idle();
      int n = 0;
      while (bus.busy && n < 400) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("idle_timeout", 32'(n < 400), 32'd1);
   endtask
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
   initial begin
      bus.rx = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_flag", 32'(bus.po_flag), 32'd0);
      check("rst_ferr", 32'(bus.frame_err), 32'd0);
      check("rst_data", 32'(bus.po_data), 32'h00);
      rst = 1'b0;
      drive(1'b1, 10);
      exp_q.push_back(8'hA5);
      send(8'hA5, 1'b1);
      drive(1'b1, 20);
      check("a5_flags", 32'(flag_cnt), 32'd1);
      check("a5_ferr", 32'(ferr_cnt), 32'd0);
      check("a5_busy", 32'(bus.busy), 32'd0);
      check("a5_latency", 32'(last_lat >= 154 && last_lat <= 156), 32'd1);
      foreach (exp_q[i]) ;
      exp_q.push_back(8'h02);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h34);
      exp_q.push_back(8'h12);
      send(8'h02, 1'b1);
      send(8'h00, 1'b1);
      send(8'h34, 1'b1);
      send(8'h12, 1'b1);
      drive(1'b1, 20);
      check("b2b_flags", 32'(flag_cnt), 32'd5);
      check("b2b_queue", 32'(exp_q.size()), 32'd0);
      drive(1'b0, 4);
      drive(1'b1, 5);
      check("glitch_busy_start", 32'(bus.busy), 32'd1);
      drive(1'b1, 30);
      check("glitch_busy", 32'(bus.busy), 32'd0);
      check("glitch_flags", 32'(flag_cnt), 32'd5);
      check("glitch_ferr", 32'(ferr_cnt), 32'd0);
      send(8'h3C, 1'b0);
      drive(1'b0, 100);
      check("break_busy", 32'(bus.busy), 32'd1);
      drive(1'b1, 20);
      check("break_ferr", 32'(ferr_cnt), 32'd1);
      check("break_flags", 32'(flag_cnt), 32'd5);
      check("break_data", 32'(bus.po_data), 32'h12);
      wait_idle();
      exp_q.push_back(8'h55);
      send(8'h55, 1'b1);
      drive(1'b1, 20);
      check("after_break_flags", 32'(flag_cnt), 32'd6);
      drive(1'b0, BD);
      for (int i = 0; i < 4; i++) drive(1'b1, BD);
      drive(1'b1, 8);
      rst = 1'b1;
      drive(1'b1, 2);
      rst = 1'b0;
      drive(1'b1, 8 + 3 * BD + BD + 20);
      check("rst_mid_data", 32'(bus.po_data), 32'h00);
      check("rst_mid_flags", 32'(flag_cnt), 32'd6);
      check("rst_mid_ferr", 32'(ferr_cnt), 32'd1);
      check("rst_mid_busy", 32'(bus.busy), 32'd0);
      exp_q.push_back(8'h81);
      send(8'h81, 1'b1);
      drive(1'b1, 20);
      check("post_rst_data", 32'(bus.po_data), 32'h81);
      check("post_rst_flags", 32'(flag_cnt), 32'd7);
      check("final_queue", 32'(exp_q.size()), 32'd0);
      check("pulse_rules", 32'(viol), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/uart_byte_receiver.md
UART_BYTE_RECEIVER -- requirements
Module: uart_byte_receiver

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, serial bit rate; BAUD_DIV = CLK_FREQ/BAUD (integer, truncated), SHALL be >= 4.
REQ-003 CLK  input  1  system clock; all logic on rising edge; one clock only.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 rx  input  1  asynchronous serial line; idle high; 8N1 framing, LSB first.
REQ-006 po_data  output  8  last correctly framed byte; held until the next good byte.
REQ-007 po_flag  output  1  one-cycle pulse; po_data valid in the same cycle.
REQ-008 frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-009 busy  output  1  high whenever the state is not IDLE.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer (both flops reset to 1); all decisions use the synchronized value rx_s and the previous value rx_d.
REQ-011 States: IDLE, START, DATA, STOP, WAIT_IDLE; binary encoded; no other states reachable.
REQ-012 IDLE: a falling edge (rx_d=1, rx_s=0) -> START, baud counter cleared to 0.
REQ-013 Baud counter: increments every cycle outside IDLE; the sample point is the cycle with counter == terminal, after which the counter is cleared.
REQ-014 START terminal = BAUD_DIV/2 - 1 (mid start bit); if rx_s=1 at sample -> IDLE (glitch rejected, no outputs); else -> DATA, bit index 0.
REQ-015 DATA terminal = BAUD_DIV - 1; each sample shifts rx_s into bit[index], LSB first; after index 7 -> STOP.
REQ-016 STOP terminal = BAUD_DIV - 1; rx_s=1 -> po_data <= shift register, po_flag=1 for exactly the next cycle, -> IDLE.
REQ-017 STOP with rx_s=0 -> frame_err=1 for exactly one cycle, po_data unchanged, po_flag stays 0, -> WAIT_IDLE.
REQ-018 WAIT_IDLE: remain until rx_s=1, then -> IDLE; a held-low line (break) SHALL produce exactly one frame_err.
REQ-019 po_flag and frame_err SHALL never be high in the same cycle and never high for two consecutive cycles.
REQ-020 Latency: po_flag SHALL rise 1 cycle after the stop-bit sample, i.e. 2 + BAUD_DIV/2 + 9*BAUD_DIV + 1 cycles (+/-1 from edge alignment) after the rx falling edge.
REQ-021 A new falling edge is only recognized in IDLE; back-to-back frames (stop bit immediately followed by start bit) SHALL both be received.

Reset
REQ-022 RESET=1 at a rising edge: state IDLE, counter 0, bit index 0, shift register 0x00, po_data 0x00, po_flag 0, frame_err 0, busy 0, synchronizer flops 1.
REQ-023 RESET asserted mid-frame SHALL abort the frame without any po_flag or frame_err pulse; reception resumes on the next falling edge after RESET deasserts.
REQ-024 RESET has priority over every state transition and output pulse in the same cycle.

Structure
REQ-025 Shared package uart_pkg: state encoding constants, BAUD_DIV derivation, bit-count constant 8.
REQ-026 One sub-module rx_baud_counter (clear, enable, terminal value in; sample pulse out); synchronizer and FSM stay in the top.
REQ-027 Outputs po_data/po_flag SHALL match the byte-valid interface of the existing program loader (byte + one-cycle valid), so the block is a drop-in feeder.

Verification (CLK_FREQ=1_600_000, BAUD=100_000, BAUD_DIV=16)
REQ-028 Frame 0xA5 with valid stop -> single po_flag, po_data=0xA5, frame_err never high, busy low after.
REQ-029 Frames 0x02,0x00,0x34,0x12 back-to-back, no idle gap -> four po_flag pulses with data in that order.
REQ-030 Low glitch of 4 cycles on idle line -> returns to IDLE at start sample, no po_flag, no frame_err.
REQ-031 Frame 0x3C with stop bit 0, line then held low 100 cycles, then high -> one frame_err, po_data keeps prior value, next 0x55 frame received.
REQ-032 RESET pulsed during bit 4 of frame 0xFF -> no pulses; po_data=0x00; following frame 0x81 -> po_data=0x81.
REQ-033 Latency check on 0xA5: po_flag within 2+8+144+1 +/-1 cycles of the start-bit falling edge.
